// File: rtl/pipeline_stall_controller_pkg.sv
// Shared core package for the pipeline stall controller.
// Holds the memory-wait FSM state type, the per-stage control bundle that
// the pipeline registers consume, the fixed control patterns used in reset
// and error, and a helper that reduces a control bundle to "any flush".
package pipeline_stall_controller_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } stall_state_t;

  // One enable and one flush per pipeline register; the PC has no flush.
  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic id_ex_en;
    logic ex_mem_en;
    logic mem_wb_en;
    logic if_id_flush;
    logic id_ex_flush;
    logic ex_mem_flush;
    logic mem_wb_flush;
  } stage_ctrl_t;

  // Free-running pipeline: everything advances, nothing is squashed.
  localparam stage_ctrl_t CTRL_RUN = '{
    pc_en: 1'b1, if_id_en: 1'b1, id_ex_en: 1'b1, ex_mem_en: 1'b1, mem_wb_en: 1'b1,
    if_id_flush: 1'b0, id_ex_flush: 1'b0, ex_mem_flush: 1'b0, mem_wb_flush: 1'b0
  };

  // While reset is held every pipeline register is loaded with a bubble.
  localparam stage_ctrl_t CTRL_RESET = '{
    pc_en: 1'b0, if_id_en: 1'b0, id_ex_en: 1'b0, ex_mem_en: 1'b0, mem_wb_en: 1'b0,
    if_id_flush: 1'b1, id_ex_flush: 1'b1, ex_mem_flush: 1'b1, mem_wb_flush: 1'b1
  };

  // Halted core: all registers frozen in place so the failing state can be inspected.
  localparam stage_ctrl_t CTRL_HALT = '{
    pc_en: 1'b0, if_id_en: 1'b0, id_ex_en: 1'b0, ex_mem_en: 1'b0, mem_wb_en: 1'b0,
    if_id_flush: 1'b0, id_ex_flush: 1'b0, ex_mem_flush: 1'b0, mem_wb_flush: 1'b0
  };

  function automatic logic anyFlush(input stage_ctrl_t c);
    return c.if_id_flush | c.id_ex_flush | c.ex_mem_flush | c.mem_wb_flush;
  endfunction

endpackage

// File: rtl/pipeline_stall_controller_sat_counter.sv
// Saturating up-counter used for the stall/flush performance counters.
// Ports:
//   clk     - clock
//   rst     - synchronous active-high reset, clears the count
//   i_inc   - count one event this cycle
//   o_count - current count; sticks at all-ones instead of wrapping
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_inc,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  // Increment only while below all-ones so the value never wraps back to zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_inc && (r_count != '1)) begin
      r_count <= r_count + W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/pipeline_stall_controller.sv
// Pipeline stall controller: merges load-use hazards, EX branch redirects and
// instruction/data memory wait states into per-stage enable/flush controls.
// A small FSM tracks outstanding dmem waits and halts the core on timeout.
// Ports:
//   clk, rst                       - clock, synchronous active-high reset
//   load_use_stall/load_use_flush  - ID hazard detection requests
//   branch_taken_ex                - taken branch/jump resolved in EX
//   imem_ready                     - fetch data valid this cycle
//   dmem_req_mem, dmem_ready       - dmem access in MEM and its completion
//   pc_en, *_en, *_flush           - stage controls (flush wins over enable)
//   halted, mem_timeout            - ERROR state, sticky dmem timeout flag
//   stall_cycles, flush_count      - saturating performance counters
module pipeline_stall_controller
  import pipeline_stall_controller_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 256,
  parameter int TO_W        = $clog2(MEM_TIMEOUT + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_use_stall,
  input  logic             load_use_flush,
  input  logic             branch_taken_ex,
  input  logic             imem_ready,
  input  logic             dmem_req_mem,
  input  logic             dmem_ready,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic             mem_wb_flush,
  output logic             halted,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam logic [TO_W-1:0] WAIT_LAST = TO_W'(MEM_TIMEOUT - 1);

  stall_state_t    r_state;
  stall_state_t    w_stateNext;
  logic [TO_W-1:0] r_waitCnt;
  logic [TO_W-1:0] w_waitCntNext;
  logic            r_memTimeout;
  logic            w_timeoutSet;
  logic            w_dmemWait;
  logic            w_halted;
  stage_ctrl_t     w_ctrl;

  // Once MEM_WAIT is entered the wait persists until dmem_ready, even if the
  // request line is momentarily dropped by the frozen MEM stage.
  assign w_dmemWait = ((r_state == MEM_WAIT) || dmem_req_mem) && !dmem_ready;

  // Stage control decode: reset, then halt, then the hazard priority chain.
  // A dmem wait freezes everything up to EX/MEM, so a concurrent branch stays
  // parked in EX and redirects in the cycle the access finally completes.
  always_comb begin
    w_ctrl   = CTRL_RUN;
    w_halted = 1'b0;
    if (rst) begin
      w_ctrl = CTRL_RESET;
    end else if (r_state == ERROR) begin
      w_ctrl   = CTRL_HALT;
      w_halted = 1'b1;
    end else if (w_dmemWait) begin
      w_ctrl.pc_en        = 1'b0;
      w_ctrl.if_id_en     = 1'b0;
      w_ctrl.id_ex_en     = 1'b0;
      w_ctrl.ex_mem_en    = 1'b0;
      w_ctrl.mem_wb_flush = 1'b1;
    end else if (branch_taken_ex) begin
      w_ctrl.if_id_flush = 1'b1;
      w_ctrl.id_ex_flush = 1'b1;
    end else begin
      if (load_use_stall) begin
        w_ctrl.pc_en       = 1'b0;
        w_ctrl.if_id_en    = 1'b0;
        w_ctrl.id_ex_flush = 1'b1;
      end else if (!imem_ready) begin
        w_ctrl.pc_en       = 1'b0;
        w_ctrl.if_id_flush = 1'b1;
      end
      if (load_use_flush) begin
        w_ctrl.id_ex_flush = 1'b1;
      end
    end
  end

  // Memory-wait FSM next state. wait_cnt counts frozen cycles already spent
  // waiting; reaching MEM_TIMEOUT-1 with dmem still busy means this is the
  // last permitted frozen cycle, so the next state is ERROR.
  always_comb begin
    w_stateNext   = r_state;
    w_waitCntNext = r_waitCnt;
    w_timeoutSet  = 1'b0;
    case (r_state)
      RUN: begin
        if (w_dmemWait) begin
          w_stateNext   = MEM_WAIT;
          w_waitCntNext = TO_W'(1);
        end
      end
      MEM_WAIT: begin
        if (dmem_ready) begin
          w_stateNext   = RUN;
          w_waitCntNext = '0;
        end else if (r_waitCnt == WAIT_LAST) begin
          w_stateNext   = ERROR;
          w_waitCntNext = '0;
          w_timeoutSet  = 1'b1;
        end else begin
          w_waitCntNext = r_waitCnt + TO_W'(1);
        end
      end
      ERROR: begin
        w_stateNext = ERROR;
      end
      default: begin
        w_stateNext   = RUN;
        w_waitCntNext = '0;
      end
    endcase
  end

  // State, wait counter and sticky timeout flag; reset wins even mid-wait.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= RUN;
      r_waitCnt    <= '0;
      r_memTimeout <= 1'b0;
    end else begin
      r_state   <= w_stateNext;
      r_waitCnt <= w_waitCntNext;
      if (w_timeoutSet) begin
        r_memTimeout <= 1'b1;
      end
    end
  end

  // A halted core holds pc_en low forever; that is not counted as stalling.
  sat_counter #(.W(CNT_W)) u_stallCounter (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (!w_ctrl.pc_en && (r_state != ERROR)),
    .o_count (stall_cycles)
  );

  sat_counter #(.W(CNT_W)) u_flushCounter (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (anyFlush(w_ctrl) && !rst),
    .o_count (flush_count)
  );

  assign pc_en        = w_ctrl.pc_en;
  assign if_id_en     = w_ctrl.if_id_en;
  assign id_ex_en     = w_ctrl.id_ex_en;
  assign ex_mem_en    = w_ctrl.ex_mem_en;
  assign mem_wb_en    = w_ctrl.mem_wb_en;
  assign if_id_flush  = w_ctrl.if_id_flush;
  assign id_ex_flush  = w_ctrl.id_ex_flush;
  assign ex_mem_flush = w_ctrl.ex_mem_flush;
  assign mem_wb_flush = w_ctrl.mem_wb_flush;
  assign halted       = w_halted;
  assign mem_timeout  = r_memTimeout;

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Self-checking bench for pipeline_stall_controller: a table of single-cycle
// decode vectors, hand-written multi-cycle sequences (reset, load-use,
// dmem wait with branch, timeout, counter saturation) and a random run,
// all checked against a behavioural model of the controller.
module tb_pipeline_stall_controller;

  localparam int CNT_W = 3;
  localparam int MT    = 4;
  localparam int SAT   = 7;

  logic clk = 1'b0;
  logic rst, load_use_stall, load_use_flush, branch_taken_ex;
  logic imem_ready, dmem_req_mem, dmem_ready;
  logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;
  logic halted, mem_timeout;
  logic [CNT_W-1:0] stall_cycles, flush_count;

  always #5 clk = ~clk;

  pipeline_stall_controller #(.CNT_W(CNT_W), .MEM_TIMEOUT(MT)) dut (
    .clk(clk), .rst(rst),
    .load_use_stall(load_use_stall), .load_use_flush(load_use_flush),
    .branch_taken_ex(branch_taken_ex), .imem_ready(imem_ready),
    .dmem_req_mem(dmem_req_mem), .dmem_ready(dmem_ready),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
    .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .ex_mem_flush(ex_mem_flush), .mem_wb_flush(mem_wb_flush),
    .halted(halted), .mem_timeout(mem_timeout),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  typedef struct packed {
    logic rst, lus, luf, br, imem, dreq, drdy;
  } in_t;

  // Output vector order: {pc, ifid_en, idex_en, exmem_en, memwb_en,
  //                       ifid_fl, idex_fl, exmem_fl, memwb_fl, halted}
  typedef struct packed {
    in_t        in;
    logic [9:0] exp;
  } vec_t;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  bit mWaiting, mHalted, mTimeout, mKnown;
  int mWaitCycles, mStalls, mFlushes;

  function automatic in_t mk(input logic r, lus, luf, br, imem, dreq, drdy);
    in_t x;
    x.rst = r; x.lus = lus; x.luf = luf; x.br = br;
    x.imem = imem; x.dreq = dreq; x.drdy = drdy;
    return x;
  endfunction

  function automatic logic [9:0] modelOutputs(input in_t x);
    logic en[5];
    logic fl[5];
    logic h;
    for (int i = 0; i < 5; i++) begin en[i] = 1'b1; fl[i] = 1'b0; end
    h = 1'b0;
    if (x.rst) begin
      for (int i = 0; i < 5; i++) begin en[i] = 1'b0; fl[i] = 1'b1; end
    end else if (mHalted) begin
      for (int i = 0; i < 5; i++) en[i] = 1'b0;
      h = 1'b1;
    end else if ((mWaiting || x.dreq) && !x.drdy) begin
      for (int i = 0; i < 4; i++) en[i] = 1'b0;
      fl[4] = 1'b1;
    end else if (x.br) begin
      fl[1] = 1'b1; fl[2] = 1'b1;
    end else begin
      if (x.lus) begin
        en[0] = 1'b0; en[1] = 1'b0; fl[2] = 1'b1;
      end else if (!x.imem) begin
        en[0] = 1'b0; fl[1] = 1'b1;
      end
      if (x.luf) fl[2] = 1'b1;
    end
    return {en[0], en[1], en[2], en[3], en[4], fl[1], fl[2], fl[3], fl[4], h};
  endfunction

  function automatic logic [9:0] dutOutputs();
    return {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
            if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush, halted};
  endfunction

  task automatic applyStimulus(input in_t x);
    rst = x.rst; load_use_stall = x.lus; load_use_flush = x.luf;
    branch_taken_ex = x.br; imem_ready = x.imem;
    dmem_req_mem = x.dreq; dmem_ready = x.drdy;
  endtask

  task automatic checkOutput(input string name, input logic [9:0] act, input logic [9:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkVal(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs after the falling edge, compare against the
  // model, then advance the model to match the coming rising edge.
  task automatic cycle(input in_t x);
    logic [9:0] exp;
    @(negedge clk);
    applyStimulus(x);
    #1;
    exp = modelOutputs(x);
    checkOutput("ctrl", dutOutputs(), exp);
    if (mKnown) begin
      checkVal("mem_timeout", int'(mem_timeout), int'(mTimeout));
      checkVal("stall_cycles", int'(stall_cycles), mStalls);
      checkVal("flush_count", int'(flush_count), mFlushes);
    end
    if (x.rst) begin
      mWaiting = 0; mHalted = 0; mTimeout = 0; mKnown = 1;
      mWaitCycles = 0; mStalls = 0; mFlushes = 0;
    end else begin
      if (!exp[9] && !mHalted && mStalls < SAT) mStalls++;
      if ((|exp[4:1]) && mFlushes < SAT) mFlushes++;
      if (!mHalted) begin
        if ((mWaiting || x.dreq) && !x.drdy) begin
          if (!mWaiting) begin
            mWaiting = 1; mWaitCycles = 1;
          end else if (mWaitCycles == MT - 1) begin
            mWaiting = 0; mHalted = 1; mTimeout = 1;
          end else begin
            mWaitCycles++;
          end
        end else begin
          mWaiting = 0; mWaitCycles = 0;
        end
      end
    end
  endtask

  vec_t vecs[11];
  in_t  idle;
  in_t  rx;

  initial begin
    idle = mk(0, 0, 0, 0, 1, 0, 1);
    //                 rst lus luf br imem dreq drdy     expected
    vecs[0]  = '{mk(0, 0, 0, 0, 1, 0, 1), 10'b11111_0000_0};
    vecs[1]  = '{mk(0, 1, 1, 0, 1, 0, 1), 10'b00111_0100_0};
    vecs[2]  = '{mk(0, 0, 1, 0, 1, 0, 1), 10'b11111_0100_0};
    vecs[3]  = '{mk(0, 0, 0, 0, 0, 0, 1), 10'b01111_1000_0};
    vecs[4]  = '{mk(0, 1, 0, 1, 1, 0, 1), 10'b11111_1100_0};
    vecs[5]  = '{mk(0, 0, 0, 1, 0, 0, 1), 10'b11111_1100_0};
    vecs[6]  = '{mk(0, 0, 0, 1, 1, 1, 0), 10'b00001_0001_0};
    vecs[7]  = '{mk(0, 1, 0, 0, 1, 1, 1), 10'b00111_0100_0};
    vecs[8]  = '{mk(0, 1, 0, 0, 0, 0, 1), 10'b00111_0100_0};
    vecs[9]  = '{mk(1, 1, 1, 1, 0, 1, 0), 10'b00000_1111_0};
    vecs[10] = '{mk(0, 1, 1, 0, 0, 1, 0), 10'b00001_0001_0};

    // Reset held two cycles, then idle
    cycle(mk(1, 0, 0, 0, 1, 0, 1));
    cycle(mk(1, 0, 0, 0, 1, 0, 1));
    cycle(idle);
    checkOutput("post_reset_ctrl", dutOutputs(), 10'b11111_0000_0);
    checkVal("post_reset_stalls", int'(stall_cycles), 0);

    // Single-cycle decode table; idle is restored before each rising edge
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      applyStimulus(vecs[i].in);
      #1;
      checkOutput($sformatf("vec%0d", i), dutOutputs(), vecs[i].exp);
      #1;
      applyStimulus(idle);
    end

    // Load-use for one cycle
    cycle(mk(1, 0, 0, 0, 1, 0, 1));
    cycle(mk(0, 1, 1, 0, 1, 0, 1));
    cycle(idle);
    checkVal("lu_stalls", int'(stall_cycles), 1);
    checkVal("lu_flushes", int'(flush_count), 1);

    // dmem wait 3 cycles with branch held in EX, then completion
    cycle(mk(1, 0, 0, 0, 1, 0, 1));
    for (int i = 0; i < 3; i++) cycle(mk(0, 0, 0, 1, 1, 1, 0));
    cycle(mk(0, 0, 0, 1, 1, 1, 1));
    checkOutput("redirect_on_ready", dutOutputs(), 10'b11111_1100_0);
    cycle(idle);
    checkVal("dmem_stalls", int'(stall_cycles), 3);
    checkVal("dmem_flushes", int'(flush_count), 4);
    checkVal("dmem_halted", int'(halted), 0);

    // Timeout: dmem never ready
    cycle(mk(1, 0, 0, 0, 1, 0, 1));
    for (int i = 0; i < MT; i++) cycle(mk(0, 0, 0, 0, 1, 1, 0));
    cycle(mk(0, 0, 0, 0, 1, 1, 0));
    checkOutput("error_ctrl", dutOutputs(), 10'b00000_0000_1);
    checkVal("timeout_flag", int'(mem_timeout), 1);
    checkVal("timeout_stalls", int'(stall_cycles), MT);
    cycle(mk(0, 0, 0, 0, 1, 0, 1));
    checkVal("error_sticky", int'(halted), 1);
    cycle(mk(1, 0, 0, 0, 1, 0, 1));
    cycle(idle);
    checkVal("rst_clears_halt", int'(halted), 0);
    checkVal("rst_clears_timeout", int'(mem_timeout), 0);

    // Counter saturation: 10 imem wait cycles
    cycle(mk(1, 0, 0, 0, 1, 0, 1));
    for (int i = 0; i < 10; i++) cycle(mk(0, 0, 0, 0, 0, 0, 1));
    cycle(idle);
    checkVal("sat_stalls", int'(stall_cycles), SAT);
    checkVal("sat_flushes", int'(flush_count), SAT);
    cycle(mk(0, 0, 0, 0, 0, 0, 1));
    cycle(idle);
    checkVal("sat_hold", int'(stall_cycles), SAT);

    // Randomized run against the model
    cycle(mk(1, 0, 0, 0, 1, 0, 1));
    for (int n = 0; n < 400; n++) begin
      rx = mk(logic'($urandom_range(0, 39) == 0),
              logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)),
              logic'($urandom_range(0, 3) == 0),
              logic'($urandom_range(0, 3) != 0),
              logic'($urandom_range(0, 1)),
              logic'($urandom_range(0, 3) != 0));
      if ((n % 64) >= 58) begin
        rx.rst = 1'b0; rx.dreq = 1'b1; rx.drdy = 1'b0;
      end
      cycle(rx);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
